// File: rtl/song_reader_pkg.sv
// Shared definitions for the song reader: FSM state codes, ROM word layout
// and a helper that builds a ROM word from its two fields.
package song_reader_pkg;

  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;

  // ROM word layout: [11:6] note index, [5:0] duration in beats
  localparam int NOTE_MSB = 11;
  localparam int NOTE_LSB = 6;
  localparam int DUR_MSB  = 5;
  localparam int DUR_LSB  = 0;

  // A zero duration marks the end of a song; the note field is don't-care
  localparam logic [DUR_W-1:0] END_MARKER = 6'd0;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } rom_word_t;

  function automatic logic [NOTE_W+DUR_W-1:0] make_word(input logic [NOTE_W-1:0] note,
                                                        input logic [DUR_W-1:0]  dur);
    logic [NOTE_W+DUR_W-1:0] w;
    w = '0;
    w[NOTE_MSB:NOTE_LSB] = note;
    w[DUR_MSB:DUR_LSB]   = dur;
    return w;
  endfunction

endpackage

// File: rtl/song_reader_if.sv
// Control/handshake bundle between the top-level play controls, the song
// reader and the note player. The master side drives play/song/note_done.
interface song_reader_if
  import song_reader_pkg::*;
#(
  parameter int SONG_BITS = 2
);
  logic                 play;
  logic [SONG_BITS-1:0] song;
  logic                 note_done;
  logic                 new_note;
  logic [NOTE_W-1:0]    note_to_load;
  logic [DUR_W-1:0]     duration_to_load;
  logic                 song_done;

  modport master (
    output play, song, note_done,
    input  new_note, note_to_load, duration_to_load, song_done
  );

  modport slave (
    input  play, song, note_done,
    output new_note, note_to_load, duration_to_load, song_done
  );
endinterface

// File: rtl/song_reader_rom.sv
// Song ROM with a registered read port (one clock of latency). Contents come
// from the INIT image, which the integrator generates from the song file.
module song_rom #(
  parameter int AW     = 7,
  parameter int DATA_W = 12,
  parameter logic [(1 << AW) * DATA_W - 1:0] INIT = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AW-1:0]     addr_i,
  output logic [DATA_W-1:0] dout_o
);
  localparam int DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] dout_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    assign mem[i] = INIT[i*DATA_W +: DATA_W];
  end

  // Registered read: the word for addr_i appears after the next rising edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q <= '0;
    end else begin
      dout_q <= mem[addr_i];
    end
  end

  assign dout_o = dout_q;
endmodule

// File: rtl/song_reader.sv
// Note sequencer: walks one song of the ROM, hands each (note, duration)
// pair to the note player with a new_note pulse, waits for note_done, and
// pulses song_done when the song ends (zero duration or last slot).
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | addr at slot 0, waiting for play
//   FETCH | ROM word for {song_q, addr_q} is being read
//   CHECK | ROM word valid: end marker -> DONE, else load note -> WAIT
//   WAIT  | note playing, waiting for note_done (accepted even if paused)
//   DONE  | song_done pulsed on entry, parked until play drops
module song_reader
  import song_reader_pkg::*;
#(
  parameter int SONG_BITS = 2,
  parameter int NOTE_BITS = 5,
  parameter int DATA_W    = 12,
  parameter logic [(1 << (SONG_BITS + NOTE_BITS)) * DATA_W - 1:0] ROM_INIT = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  song_reader_if.slave bus
);

  logic [2:0]           state_q, state_d;
  logic [NOTE_BITS-1:0] addr_q, addr_d;
  logic [SONG_BITS-1:0] song_q, song_d;
  rom_word_t            cur_q, cur_d;
  logic                 new_note_q, new_note_d;
  logic                 song_done_q, song_done_d;

  logic [DATA_W-1:0]    rom_dout;
  logic [NOTE_W-1:0]    rom_note;
  logic [DUR_W-1:0]     rom_dur;

  song_rom #(
    .AW     (SONG_BITS + NOTE_BITS),
    .DATA_W (DATA_W),
    .INIT   (ROM_INIT)
  ) u_rom (
    .clk     (clk),
    .reset_n (reset_n),
    .addr_i  ({song_q, addr_q}),
    .dout_o  (rom_dout)
  );

  assign rom_note = rom_dout[NOTE_MSB:NOTE_LSB];
  assign rom_dur  = rom_dout[DUR_MSB:DUR_LSB];

  // Next-state logic; a song change overrides everything, and the pulse
  // outputs default low so each one lasts exactly one cycle
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    song_d      = song_q;
    cur_d       = cur_q;
    new_note_d  = 1'b0;
    song_done_d = 1'b0;

    if (bus.song != song_q) begin
      song_d  = bus.song;
      addr_d  = '0;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.play) state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (bus.play) state_d = ST_CHECK;
        end
        ST_CHECK: begin
          if (bus.play) begin
            if (rom_dur == END_MARKER) begin
              state_d     = ST_DONE;
              song_done_d = 1'b1;
              addr_d      = '0;
            end else begin
              cur_d.note = rom_note;
              cur_d.dur  = rom_dur;
              new_note_d = 1'b1;
              state_d    = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // note_done is honoured while paused so the player never stalls us
          if (bus.note_done) begin
            if (&addr_q) begin
              state_d     = ST_DONE;
              song_done_d = 1'b1;
              addr_d      = '0;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          addr_d = '0;
          if (!bus.play) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          addr_d  = '0;
        end
      endcase
    end
  end

  // State, address, song select and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      song_q      <= '0;
      cur_q       <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      song_q      <= song_d;
      cur_q       <= cur_d;
      new_note_q  <= new_note_d;
      song_done_q <= song_done_d;
    end
  end

  assign bus.new_note         = new_note_q;
  assign bus.note_to_load     = cur_q.note;
  assign bus.duration_to_load = cur_q.dur;
  assign bus.song_done        = song_done_q;

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: a per-cycle vector table for the short song,
// hand-written sequences for full song / pause / song change / reset, and a
// randomized run checked by a transaction-level song model.
module tb_song_reader;
  import song_reader_pkg::*;

  localparam int ROM_BITS = 128 * 12;

  function automatic logic [ROM_BITS-1:0] build_rom();
    logic [ROM_BITS-1:0] r;
    r = '0;
    for (int k = 0; k < 32; k++) begin
      // song 0: two notes then end marker
      if (k == 0)      r[(0*32+k)*12 +: 12] = make_word(6'd12, 6'd4);
      else if (k == 1) r[(0*32+k)*12 +: 12] = make_word(6'd20, 6'd2);
      else if (k == 2) r[(0*32+k)*12 +: 12] = make_word(6'd0, 6'd0);
      else             r[(0*32+k)*12 +: 12] = make_word(6'd1, 6'd1);
      // song 1: 32 nonzero-duration slots, slot 2 is a rest
      if (k == 2) r[(1*32+k)*12 +: 12] = make_word(6'd0, 6'd3);
      else        r[(1*32+k)*12 +: 12] = make_word(6'((k*7+3)%64), 6'((k%9)+1));
      // song 2: seven notes, end marker with a nonzero note field at slot 7
      if (k < 7)       r[(2*32+k)*12 +: 12] = make_word(6'(40+k), 6'(k+2));
      else if (k == 7) r[(2*32+k)*12 +: 12] = make_word(6'd5, 6'd0);
      else             r[(2*32+k)*12 +: 12] = make_word(6'd9, 6'd9);
      // song 3: twenty notes then end marker
      if (k == 20) r[(3*32+k)*12 +: 12] = make_word(6'd7, 6'd0);
      else         r[(3*32+k)*12 +: 12] = make_word(6'((k*13+5)%64), 6'(((k*5)%7)+1));
    end
    return r;
  endfunction

  localparam logic [ROM_BITS-1:0] ROM = build_rom();

  logic clk;
  logic reset_n;

  song_reader_if #(.SONG_BITS(2)) bus();

  song_reader #(
    .SONG_BITS (2),
    .NOTE_BITS (5),
    .DATA_W    (12),
    .ROM_INIT  (ROM)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [5:0] m_note [4][32];
  logic [5:0] m_dur  [4][32];
  int         m_len  [4];

  typedef struct {
    bit play;
    bit nd;
    bit exp_nn;
    int exp_note;
    int exp_dur;
    bit exp_sd;
  } vec_t;

  vec_t tbl [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.play      = 1'b0;
    bus.note_done = 1'b0;
    bus.song      = 2'd0;
    reset_n       = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic pulse_done();
    bus.note_done = 1'b1;
    tick();
    bus.note_done = 1'b0;
  endtask

  task automatic wait_note(input int budget, output int cycles, output bit sd_seen);
    cycles  = 0;
    sd_seen = 1'b0;
    while (!bus.new_note && cycles < budget) begin
      tick();
      cycles++;
      if (bus.song_done) sd_seen = 1'b1;
    end
    check("note_timeout", 32'(bus.new_note), 32'd1);
  endtask

  int  cyc;
  bit  sdseen;
  int  nnotes;
  int  paused_nn;
  int  sd_early;

  // random-phase model state
  int         idx;
  bit         waiting;
  bit         finished;
  logic [1:0] msong;
  bit         p, nd, chg;
  logic [1:0] s;
  int         rnd_notes;
  int         rnd_dones;
  logic [ROM_BITS-1:0] rom_img;

  initial begin
    reset_n       = 1'b0;
    bus.play      = 1'b0;
    bus.song      = 2'd0;
    bus.note_done = 1'b0;

    // expected song contents: each song ends at its first zero duration
    rom_img = ROM;
    for (int sg = 0; sg < 4; sg++) begin
      bit ended;
      ended     = 1'b0;
      m_len[sg] = 32;
      for (int k = 0; k < 32; k++) begin
        m_note[sg][k] = rom_img[(sg*32+k)*12+6 +: 6];
        m_dur[sg][k]  = rom_img[(sg*32+k)*12   +: 6];
        if (!ended && m_dur[sg][k] == 6'd0) begin
          m_len[sg] = k;
          ended     = 1'b1;
        end
      end
    end

    // ---------------- reset values ----------------
    do_reset();
    check("rst_new_note",  32'(bus.new_note), 0);
    check("rst_note",      32'(bus.note_to_load), 0);
    check("rst_dur",       32'(bus.duration_to_load), 0);
    check("rst_song_done", 32'(bus.song_done), 0);
    check("rst_state",     32'(dut.state_q), 32'(ST_IDLE));

    // ---------------- short song, cycle by cycle ----------------
    tbl[0]  = '{1, 0, 0,  0, 0, 0};  // IDLE -> FETCH
    tbl[1]  = '{1, 1, 0,  0, 0, 0};  // FETCH -> CHECK, stray note_done ignored
    tbl[2]  = '{1, 0, 1, 12, 4, 0};  // CHECK -> WAIT, first note
    tbl[3]  = '{1, 0, 0, 12, 4, 0};
    tbl[4]  = '{1, 1, 0, 12, 4, 0};  // note_done -> FETCH slot 1
    tbl[5]  = '{1, 0, 0, 12, 4, 0};
    tbl[6]  = '{1, 0, 1, 20, 2, 0};  // second note
    tbl[7]  = '{1, 1, 0, 20, 2, 0};
    tbl[8]  = '{1, 0, 0, 20, 2, 0};
    tbl[9]  = '{1, 0, 0, 20, 2, 1};  // end marker -> song_done
    tbl[10] = '{1, 0, 0, 20, 2, 0};  // parked in DONE
    tbl[11] = '{0, 0, 0, 20, 2, 0};  // play low -> IDLE
    for (int i = 0; i < 12; i++) begin
      bus.play      = tbl[i].play;
      bus.note_done = tbl[i].nd;
      tick();
      check($sformatf("t1_nn[%0d]", i),   32'(bus.new_note), 32'(tbl[i].exp_nn));
      check($sformatf("t1_note[%0d]", i), 32'(bus.note_to_load), tbl[i].exp_note);
      check($sformatf("t1_dur[%0d]", i),  32'(bus.duration_to_load), tbl[i].exp_dur);
      check($sformatf("t1_sd[%0d]", i),   32'(bus.song_done), 32'(tbl[i].exp_sd));
    end
    bus.note_done = 1'b0;
    check("t1_state_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // ---------------- full 32-note song, with a rest note ----------------
    do_reset();
    bus.song = 2'd1;
    bus.play = 1'b1;
    nnotes   = 0;
    sd_early = 0;
    for (int i = 0; i < 32; i++) begin
      wait_note(12, cyc, sdseen);
      if (sdseen) sd_early++;
      if (bus.new_note) nnotes++;
      if (i > 0) check("t2_latency", cyc, 2);
      check("t2_note", 32'(bus.note_to_load), 32'(m_note[1][i]));
      check("t2_dur",  32'(bus.duration_to_load), 32'(m_dur[1][i]));
      if (i == 2) begin
        check("t5_rest_note", 32'(bus.note_to_load), 0);
        check("t5_rest_dur",  32'(bus.duration_to_load), 3);
      end
      pulse_done();
      if (i < 31) check("t2_no_early_done", 32'(bus.song_done), 0);
    end
    check("t2_song_done", 32'(bus.song_done), 1);
    check("t2_note_count", nnotes, 32);
    check("t2_sd_during_song", sd_early, 0);
    check("t2_addr_zero", 32'(dut.addr_q), 0);
    tick();
    check("t2_sd_one_cycle", 32'(bus.song_done), 0);
    check("t2_no_33rd_note", 32'(bus.new_note), 0);

    // ---------------- song change mid note 5 ----------------
    do_reset();
    bus.song = 2'd1;
    bus.play = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_note(12, cyc, sdseen);
      if (i < 4) pulse_done();
    end
    tick();
    bus.song = 2'd2;
    tick();
    check("t4_nn_low",    32'(bus.new_note), 0);
    check("t4_sd_low",    32'(bus.song_done), 0);
    check("t4_note_hold", 32'(bus.note_to_load), 32'(m_note[1][4]));
    check("t4_dur_hold",  32'(bus.duration_to_load), 32'(m_dur[1][4]));
    check("t4_state",     32'(dut.state_q), 32'(ST_IDLE));
    wait_note(10, cyc, sdseen);
    check("t4_no_song_done", 32'(sdseen), 0);
    check("t4_new_note", 32'(bus.note_to_load), 32'(m_note[2][0]));
    check("t4_new_dur",  32'(bus.duration_to_load), 32'(m_dur[2][0]));

    // ---------------- pause in WAIT with note_done ----------------
    do_reset();
    bus.song = 2'd2;
    bus.play = 1'b1;
    wait_note(10, cyc, sdseen);
    check("t3_first_note", 32'(bus.note_to_load), 32'(m_note[2][0]));
    bus.play  = 1'b0;
    paused_nn = 0;
    for (int j = 0; j < 10; j++) begin
      bus.note_done = (j == 3);
      tick();
      if (bus.new_note) paused_nn++;
    end
    bus.note_done = 1'b0;
    check("t3_no_note_paused", paused_nn, 0);
    check("t3_addr_advanced", 32'(dut.addr_q), 1);
    bus.play = 1'b1;
    wait_note(6, cyc, sdseen);
    check("t3_resume_note", 32'(bus.note_to_load), 32'(m_note[2][1]));
    check("t3_resume_dur",  32'(bus.duration_to_load), 32'(m_dur[2][1]));

    // ---------------- asynchronous reset during WAIT ----------------
    do_reset();
    bus.song = 2'd2;
    bus.play = 1'b1;
    wait_note(10, cyc, sdseen);
    #2 reset_n = 1'b0;
    #1;
    check("t6_nn",   32'(bus.new_note), 0);
    check("t6_note", 32'(bus.note_to_load), 0);
    check("t6_dur",  32'(bus.duration_to_load), 0);
    check("t6_sd",   32'(bus.song_done), 0);
    tick();
    reset_n = 1'b1;
    wait_note(10, cyc, sdseen);
    check("t6_restart_note", 32'(bus.note_to_load), 32'(m_note[2][0]));
    check("t6_restart_dur",  32'(bus.duration_to_load), 32'(m_dur[2][0]));

    // ---------------- randomized run against the song model ----------------
    do_reset();
    msong     = 2'd0;
    idx       = 0;
    waiting   = 1'b0;
    finished  = 1'b0;
    rnd_notes = 0;
    rnd_dones = 0;
    s         = 2'd0;
    for (int c = 0; c < 6000; c++) begin
      p = ($urandom_range(0, 9) != 0);
      if (finished && $urandom_range(0, 7) == 0) p = 1'b0;
      if ($urandom_range(0, 299) == 0) s = 2'($urandom_range(0, 3));
      nd = waiting ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      bus.play      = p;
      bus.song      = s;
      bus.note_done = nd;
      tick();

      chg = 1'b0;
      if (s != msong) begin
        msong    = s;
        idx      = 0;
        waiting  = 1'b0;
        finished = 1'b0;
        chg      = 1'b1;
      end else begin
        if (waiting && nd) begin
          waiting = 1'b0;
          idx++;
        end
        if (finished && !p) begin
          finished = 1'b0;
          idx      = 0;
        end
      end

      if (chg) begin
        check("rnd_change_no_nn", 32'(bus.new_note), 0);
        check("rnd_change_no_sd", 32'(bus.song_done), 0);
      end
      if (bus.new_note && bus.song_done) check("rnd_both_pulses", 1, 0);
      if (bus.new_note) begin
        rnd_notes++;
        check("rnd_nn_allowed", {29'd0, p, waiting, finished}, 32'b100);
        if (idx >= m_len[msong]) begin
          check("rnd_extra_note", idx, m_len[msong] - 1);
        end else begin
          check("rnd_note", 32'(bus.note_to_load), 32'(m_note[msong][idx]));
          check("rnd_dur",  32'(bus.duration_to_load), 32'(m_dur[msong][idx]));
        end
        waiting = 1'b1;
      end
      if (bus.song_done) begin
        rnd_dones++;
        check("rnd_sd_at_end", {idx, 1'b0, waiting, finished}, {m_len[msong], 3'b000});
        finished = 1'b1;
      end
    end
    bus.play      = 1'b0;
    bus.note_done = 1'b0;
    check("rnd_progress_notes", 32'(rnd_notes >= 100), 1);
    check("rnd_progress_dones", 32'(rnd_dones >= 1), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
